// File: rtl/issue_window.sv
// Out-of-order issue window: a compacting buffer plus this cycle's fetch lanes, a
// register scoreboard, and an oldest-first selector that fills up to ISSUE_W issue lanes.
module issue_window #(
  parameter int FETCH_W = 4,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  parameter int XLEN    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FETCH_W-1:0]           in_vld,
  input  logic [FETCH_W*XLEN-1:0]      in_instr,
  input  logic [FETCH_W*XLEN-1:0]      in_pc,
  input  logic [FETCH_W*5-1:0]         in_rd,
  input  logic [FETCH_W*5-1:0]         in_rs0,
  input  logic [FETCH_W*5-1:0]         in_rs1,
  input  logic [FETCH_W-1:0]           in_mem,
  input  logic [FETCH_W-1:0]           in_special,
  output logic [$clog2(FETCH_W+1)-1:0] in_count,
  output logic [ISSUE_W-1:0]           out_vld,
  output logic [ISSUE_W*XLEN-1:0]      out_instr,
  output logic [ISSUE_W*XLEN-1:0]      out_pc,
  input  logic                         out_rdy,
  input  logic                         wb_vld,
  input  logic [4:0]                   wb_rd,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int CNT_W = $clog2(FETCH_W+1);
  localparam int OCC_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs0;
    logic [4:0]      rs1;
    logic            mem;
    logic            special;
  } entry_t;

  entry_t                buf_q [DEPTH];
  entry_t                buf_d [DEPTH];
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [31:0]           busy_q, busy_d, set_mask;
  logic [ISSUE_W-1:0]    out_vld_q, iss_vld;
  logic [ISSUE_W*XLEN-1:0] out_instr_q, out_pc_q, iss_instr, iss_pc;

  entry_t                lane_e [FETCH_W];
  entry_t                win [DEPTH];
  logic [DEPTH-1:0]      win_v, sel;
  logic                  buf_has_special;
  logic [CNT_W-1:0]      acc_cnt;
  logic                  issue_fire;

  // Issue handshake: the bundle on out_* is offered while out_vld is nonzero and is
  // taken at a rising edge with out_rdy=1; a new bundle loads only when the old one
  // is taken or no lane is valid, otherwise out_* and the window hold.
  assign issue_fire = (out_rdy || !(|out_vld_q)) && !rst && !flush;

  always_comb begin : lane_p
    for (int l = 0; l < FETCH_W; l++) begin
      lane_e[l].instr   = in_instr[l*XLEN +: XLEN];
      lane_e[l].pc      = in_pc[l*XLEN +: XLEN];
      lane_e[l].rd      = in_rd[l*5 +: 5];
      lane_e[l].rs0     = in_rs0[l*5 +: 5];
      lane_e[l].rs1     = in_rs1[l*5 +: 5];
      lane_e[l].mem     = in_mem[l];
      lane_e[l].special = in_special[l];
    end
  end

  always_comb begin : buf_special_p
    buf_has_special = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (i < int'(occ_q) && buf_q[i].special) buf_has_special = 1'b1;
  end

  // A special lane closes the accepted prefix; a buffered special blocks all intake.
  always_comb begin : accept_p
    int  k;
    logic go;
    k  = 0;
    go = !(rst || flush || buf_has_special);
    for (int l = 0; l < FETCH_W; l++) begin
      if (go && in_vld[l] && (l < DEPTH - int'(occ_q))) k = l + 1;
      else go = 1'b0;
      if (in_special[l]) go = 1'b0;
    end
    acc_cnt = CNT_W'(k);
  end

  always_comb begin : window_p
    int j;
    for (int i = 0; i < DEPTH; i++) begin
      j        = i - int'(occ_q);
      win[i]   = '0;
      win_v[i] = 1'b0;
      if (i < int'(occ_q)) begin
        win[i]   = buf_q[i];
        win_v[i] = 1'b1;
      end else if (j < int'(acc_cnt)) begin
        win[i]   = lane_e[j];
        win_v[i] = 1'b1;
      end
    end
  end

  // Register hazards look at every older window entry, issuing or not: busy is only
  // set at the edge, so a same-cycle producer must still block its consumer.
  always_comb begin : select_p
    entry_t      e;
    logic        elig, stop, mem_pend;
    logic [31:0] older_rd, older_rs;
    int          n;
    sel       = '0;
    iss_vld   = '0;
    iss_instr = '0;
    iss_pc    = '0;
    set_mask  = '0;
    stop      = 1'b0;
    mem_pend  = 1'b0;
    older_rd  = '0;
    older_rs  = '0;
    n         = 0;
    for (int i = 0; i < DEPTH; i++) begin
      e    = win[i];
      elig = win_v[i] && issue_fire && !stop && (n < ISSUE_W);
      if (e.rs0 != 5'd0 && (busy_q[e.rs0] || older_rd[e.rs0])) elig = 1'b0;
      if (e.rs1 != 5'd0 && (busy_q[e.rs1] || older_rd[e.rs1])) elig = 1'b0;
      if (e.rd != 5'd0 && (busy_q[e.rd] || older_rd[e.rd] || older_rs[e.rd])) elig = 1'b0;
      if (e.mem && mem_pend) elig = 1'b0;
      if (e.special && i != 0) elig = 1'b0;
      if (elig) begin
        sel[i]                    = 1'b1;
        iss_vld[n]                = 1'b1;
        iss_instr[n*XLEN +: XLEN] = e.instr;
        iss_pc[n*XLEN +: XLEN]    = e.pc;
        if (e.rd != 5'd0) set_mask[e.rd] = 1'b1;
        stop = e.special;
        n    = n + 1;
      end else if (win_v[i]) begin
        mem_pend = mem_pend | e.mem;
      end
      if (win_v[i]) begin
        older_rd[e.rd]  = 1'b1;
        older_rs[e.rs0] = 1'b1;
        older_rs[e.rs1] = 1'b1;
      end
    end
  end

  always_comb begin : compact_p
    int idx;
    idx = 0;
    for (int i = 0; i < DEPTH; i++) buf_d[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (win_v[i] && !sel[i]) begin
        buf_d[idx] = win[i];
        idx        = idx + 1;
      end
    end
    occ_d = OCC_W'(idx);
  end

  // Set beats clear when an issue and a writeback hit the same register.
  always_comb begin : busy_p
    busy_d = busy_q;
    if (wb_vld && wb_rd != 5'd0) busy_d[wb_rd] = 1'b0;
    busy_d    = busy_d | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= '0;
      busy_q      <= '0;
      out_vld_q   <= '0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      if (flush) begin
        occ_q     <= '0;
        out_vld_q <= '0;
      end else begin
        occ_q <= occ_d;
        for (int i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
        if (issue_fire) begin
          out_vld_q   <= iss_vld;
          out_instr_q <= iss_instr;
          out_pc_q    <= iss_pc;
        end
      end
    end
  end

  assign in_count  = acc_cnt;
  assign out_vld   = out_vld_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_issue_window.sv
// Bench for issue_window: directed scenarios followed by random traffic, all checked
// cycle by cycle against a queue-based window model.
module tb_issue_window;
  localparam int FW = 4;
  localparam int IW = 2;
  localparam int DP = 8;
  localparam int XL = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, out_rdy, wb_vld;
  logic [4:0]        wb_rd;
  logic [FW-1:0]     in_vld, in_mem, in_special;
  logic [FW*XL-1:0]  in_instr, in_pc;
  logic [FW*5-1:0]   in_rd, in_rs0, in_rs1;
  logic [2:0]        in_count;
  logic [IW-1:0]     out_vld;
  logic [IW*XL-1:0]  out_instr, out_pc;
  logic [3:0]        occupancy;

  issue_window #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(DP), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_instr(in_instr), .in_pc(in_pc),
    .in_rd(in_rd), .in_rs0(in_rs0), .in_rs1(in_rs1), .in_mem(in_mem),
    .in_special(in_special), .in_count(in_count), .out_vld(out_vld),
    .out_instr(out_instr), .out_pc(out_pc), .out_rdy(out_rdy), .wb_vld(wb_vld),
    .wb_rd(wb_rd), .flush(flush), .occupancy(occupancy)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic        mem;
    logic        sp;
  } ent_t;

  ent_t          lanes [FW];
  logic [FW-1:0] lv;

  ent_t          m_q[$];
  logic [31:0]   m_busy;
  logic [IW-1:0] m_ovld;
  logic [31:0]   m_opc [IW];
  logic [31:0]   m_oins [IW];
  logic          model_known;

  logic [31:0]   exp_q[$];
  int            n_vec, n_err;
  logic [2:0]    obs_cnt;
  int            ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_lanes();
    for (int l = 0; l < FW; l++) begin
      lv[l]    = 1'b0;
      lanes[l] = '0;
    end
  endtask

  task automatic set_lane(input int l, input logic [4:0] rd, input logic [4:0] rs0,
                          input logic [4:0] rs1, input logic mem, input logic sp,
                          input logic [31:0] pc);
    lv[l]        = 1'b1;
    lanes[l].pc  = pc;
    lanes[l].rd  = rd;
    lanes[l].rs0 = rs0;
    lanes[l].rs1 = rs1;
    lanes[l].mem = mem;
    lanes[l].sp  = sp;
    lanes[l].instr = pc ^ {8'hC0, 3'b000, rd, rs0, rs1, mem, sp, 4'h0};
  endtask

  // Window model: queue of waiting entries, busy vector, registered issue bundle.
  task automatic model_step(output int cnt);
    ent_t          win[$];
    ent_t          kept[$];
    ent_t          e;
    logic          sp_buf, ok, stop;
    logic [31:0]   setm;
    logic [IW-1:0] nv;
    int            n;
    cnt = 0;
    if (rst) begin
      m_q.delete();
      m_busy = '0;
      m_ovld = '0;
      for (int j = 0; j < IW; j++) begin
        m_opc[j]  = '0;
        m_oins[j] = '0;
      end
      return;
    end
    if (flush) begin
      m_q.delete();
      m_ovld = '0;
      if (wb_vld && wb_rd != 5'd0) m_busy[wb_rd] = 1'b0;
      return;
    end
    win    = m_q;
    sp_buf = 1'b0;
    foreach (m_q[i]) if (m_q[i].sp) sp_buf = 1'b1;
    if (!sp_buf) begin
      for (int l = 0; l < FW; l++) begin
        if (!lv[l] || win.size() >= DP) break;
        win.push_back(lanes[l]);
        cnt++;
        if (lanes[l].sp) break;
      end
    end
    setm = '0;
    if (out_rdy || m_ovld == '0) begin
      n    = 0;
      stop = 1'b0;
      nv   = '0;
      for (int i = 0; i < win.size(); i++) begin
        e  = win[i];
        ok = !stop && n < IW;
        if (e.sp && i != 0) ok = 1'b0;
        if (e.mem) foreach (kept[k]) if (kept[k].mem) ok = 1'b0;
        for (int k = 0; k < i; k++) begin
          if (e.rs0 != 0 && win[k].rd == e.rs0) ok = 1'b0;
          if (e.rs1 != 0 && win[k].rd == e.rs1) ok = 1'b0;
          if (e.rd != 0 && (win[k].rd == e.rd || win[k].rs0 == e.rd || win[k].rs1 == e.rd)) ok = 1'b0;
        end
        if (e.rs0 != 0 && m_busy[e.rs0]) ok = 1'b0;
        if (e.rs1 != 0 && m_busy[e.rs1]) ok = 1'b0;
        if (e.rd != 0 && m_busy[e.rd]) ok = 1'b0;
        if (ok) begin
          nv[n]     = 1'b1;
          m_opc[n]  = e.pc;
          m_oins[n] = e.instr;
          if (e.rd != 0) setm[e.rd] = 1'b1;
          if (e.sp) stop = 1'b1;
          n++;
        end else begin
          kept.push_back(e);
        end
      end
      m_q    = kept;
      m_ovld = nv;
    end else begin
      m_q = win;
    end
    if (wb_vld && wb_rd != 5'd0) m_busy[wb_rd] = 1'b0;
    m_busy = m_busy | setm;
  endtask

  task automatic step();
    int ec;
    for (int l = 0; l < FW; l++) begin
      in_vld[l]           = lv[l];
      in_instr[l*XL +: XL] = lanes[l].instr;
      in_pc[l*XL +: XL]    = lanes[l].pc;
      in_rd[l*5 +: 5]      = lanes[l].rd;
      in_rs0[l*5 +: 5]     = lanes[l].rs0;
      in_rs1[l*5 +: 5]     = lanes[l].rs1;
      in_mem[l]            = lanes[l].mem;
      in_special[l]        = lanes[l].sp;
    end
    #3;
    obs_cnt = in_count;
    if (model_known) begin
      chk("occupancy", 64'(occupancy), 64'(m_q.size()));
      chk("out_vld", 64'(out_vld), 64'(m_ovld));
      for (int j = 0; j < IW; j++) begin
        if (m_ovld[j]) begin
          chk("out_pc", 64'(out_pc[j*XL +: XL]), 64'(m_opc[j]));
          chk("out_instr", 64'(out_instr[j*XL +: XL]), 64'(m_oins[j]));
        end
      end
    end
    model_step(ec);
    chk("in_count", 64'(in_count), 64'(ec));
    if (rst) model_known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_lanes();
    step();
    rst = 1'b0;
  endtask

  task automatic fetch_stream(input int total);
    clear_lanes();
    for (int l = 0; l < FW; l++)
      if (ptr + l < total) set_lane(l, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h200 + 32'(4*(ptr+l)));
  endtask

  task automatic accept_stream();
    for (int t = 0; t < int'(obs_cnt); t++) exp_q.push_back(32'h200 + 32'(4*(ptr+t)));
    ptr = ptr + int'(obs_cnt);
  endtask

  initial begin
    n_vec = 0; n_err = 0; model_known = 1'b0;
    rst = 1'b1; flush = 1'b0; out_rdy = 1'b1; wb_vld = 1'b0; wb_rd = '0;
    in_vld = '0; in_instr = '0; in_pc = '0; in_rd = '0; in_rs0 = '0; in_rs1 = '0;
    in_mem = '0; in_special = '0;

    // reset with all lanes valid
    clear_lanes();
    for (int l = 0; l < FW; l++) set_lane(l, 5'(l+1), 5'd0, 5'd0, 1'b0, 1'b0, 32'(4*l));
    step();
    step();
    chk("rst_in_count", 64'(obs_cnt), 64'd0);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    rst = 1'b0;

    // four independent ops
    step();
    chk("ind_in_count", 64'(obs_cnt), 64'd4);
    chk("ind_pc0", 64'(out_pc[31:0]), 64'h0);
    chk("ind_pc1", 64'(out_pc[63:32]), 64'h4);
    chk("ind_occ1", 64'(occupancy), 64'd2);
    clear_lanes();
    step();
    chk("ind_pc2", 64'(out_pc[31:0]), 64'h8);
    chk("ind_pc3", 64'(out_pc[63:32]), 64'hC);
    chk("ind_occ2", 64'(occupancy), 64'd0);

    // RAW hazard released by writeback
    do_reset();
    set_lane(0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 32'h40);
    set_lane(1, 5'd7, 5'd5, 5'd0, 1'b0, 1'b0, 32'h44);
    set_lane(2, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 32'h48);
    step();
    clear_lanes();
    chk("haz_pc0", 64'(out_pc[31:0]), 64'h40);
    chk("haz_pc1", 64'(out_pc[63:32]), 64'h48);
    chk("haz_occ", 64'(occupancy), 64'd1);
    step();
    wb_vld = 1'b1; wb_rd = 5'd5;
    step();
    wb_vld = 1'b0;
    chk("haz_wb_occ", 64'(occupancy), 64'd1);
    step();
    chk("haz_b_vld", 64'(out_vld), 64'b01);
    chk("haz_b_pc", 64'(out_pc[31:0]), 64'h44);
    set_lane(0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 32'h50);
    step();
    clear_lanes();
    chk("haz_busy7", 64'(occupancy), 64'd1);

    // full window waiting on r9
    do_reset();
    set_lane(0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 32'h80);
    step();
    for (int b = 0; b < 3; b++) begin
      clear_lanes();
      for (int l = 0; l < FW; l++) set_lane(l, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 32'h100 + 32'(16*b + 4*l));
      step();
    end
    chk("full_in_count", 64'(obs_cnt), 64'd0);
    chk("full_occ", 64'(occupancy), 64'd8);
    clear_lanes();
    wb_vld = 1'b1; wb_rd = 5'd9;
    step();
    wb_vld = 1'b0;
    chk("full_occ8", 64'(occupancy), 64'd8);
    step();
    chk("full_occ6", 64'(occupancy), 64'd6);
    step();
    chk("full_occ4", 64'(occupancy), 64'd4);
    for (int c = 0; c < 3; c++) step();

    // backpressure with a re-presenting fetch stream
    do_reset();
    ptr = 0;
    exp_q.delete();
    out_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      fetch_stream(12);
      step();
      accept_stream();
      chk("bp_hold_pc0", 64'(out_pc[31:0]), 64'h200);
      chk("bp_hold_vld", 64'(out_vld), 64'b11);
    end
    chk("bp_occ", 64'(occupancy), 64'd8);
    out_rdy = 1'b1;
    for (int c = 0; c < 30 && (exp_q.size() != 0 || ptr < 12); c++) begin
      for (int j = 0; j < IW; j++) begin
        if (out_vld[j]) begin
          if (exp_q.size() == 0) chk("bp_extra", 64'(out_pc[j*XL +: XL]), 64'hFFFF_FFFF_FFFF_FFFF);
          else chk("bp_order", 64'(out_pc[j*XL +: XL]), 64'(exp_q.pop_front()));
        end
      end
      fetch_stream(12);
      step();
      accept_stream();
    end
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_all_fetched", 64'(ptr), 64'd12);

    // flush keeps busy bits
    do_reset();
    out_rdy = 1'b0;
    for (int l = 0; l < FW; l++) set_lane(l, 5'(l+3), 5'd0, 5'd0, 1'b0, 1'b0, 32'h300 + 32'(4*l));
    step();
    clear_lanes();
    for (int l = 0; l < 3; l++) set_lane(l, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h310 + 32'(4*l));
    step();
    chk("fl_occ5", 64'(occupancy), 64'd5);
    chk("fl_vld11", 64'(out_vld), 64'b11);
    clear_lanes();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_occ0", 64'(occupancy), 64'd0);
    chk("fl_vld0", 64'(out_vld), 64'd0);
    out_rdy = 1'b1;
    set_lane(0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 32'h320);
    step();
    clear_lanes();
    chk("fl_busy3", 64'(occupancy), 64'd1);
    wb_vld = 1'b1; wb_rd = 5'd3;
    step();
    wb_vld = 1'b0;
    step();
    chk("fl_after_wb_vld", 64'(out_vld), 64'b01);
    chk("fl_after_wb_pc", 64'(out_pc[31:0]), 64'h320);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      flush   = ($urandom_range(0, 39) == 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      wb_vld  = 1'($urandom_range(0, 1));
      wb_rd   = 5'($urandom_range(0, 7));
      clear_lanes();
      for (int l = 0; l < int'($urandom_range(0, FW)); l++)
        set_lane(l, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                 32'h1000 + 32'(16*c + 4*l));
      step();
    end
    rst = 1'b0; flush = 1'b0; wb_vld = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
